// File: rtl/wave_clk_ctrl.sv
// -----------------------------------------------------------------------------
// wave_clk_ctrl
//
// Programmable clock-enable controller for the waveform generator datapath.
// Divides clk_in by a runtime ratio N and produces a registered divided clock
// level (clk_out) plus a one-cycle tick on the first cycle of every output
// period. Run/stop requests are honoured only on period boundaries, and new
// ratios arrive through a valid/ready handshake. A new ratio takes effect only
// when a period starts, so clk_out never glitches.
//
// Ports
//   clk_in     in   system clock (50 MHz)
//   reset      in   synchronous, active-high reset
//   start      in   level, requests RUN
//   stop       in   level, requests a stop at the end of the current period
//   cfg_valid  in   new ratio offered
//   cfg_div    in   offered ratio N (DIV_W bits, must be >= 2)
//   cfg_ready  out  controller can accept a ratio
//   cur_div    out  ratio currently in effect
//   err        out  one-cycle pulse when an offered ratio is rejected
//   clk_out    out  divided clock level, registered
//   tick       out  one-cycle pulse on the first cycle of each output period
//   busy       out  high while the controller is not IDLE
// -----------------------------------------------------------------------------
module wave_clk_ctrl #(
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic [DIV_W-1:0] cur_div,
  output logic             err,
  output logic             clk_out,
  output logic             tick,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_STOPPING = 2'd2
  } state_e;

  state_e           state_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cur_div_q;
  logic [DIV_W-1:0] pend_q;
  logic             pend_vld_q;
  logic             cfg_ready_q;
  logic             err_q;
  logic             clk_out_q;
  logic             tick_q;
  logic             busy_q;

  // Next-cycle helpers shared by the counting states.
  logic             wrap;
  logic             apply;
  logic             xfer;
  logic [DIV_W-1:0] div_d;
  logic [DIV_W-1:0] cnt_d;
  logic             clk_out_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    wrap      = (cnt_q == (cur_div_q - DIV_W'(1)));
    // A pending ratio lands immediately when idle, otherwise only at a
    // period boundary so the current period is never cut short.
    apply     = pend_vld_q && ((state_q == S_IDLE) || wrap);
    xfer      = cfg_valid && cfg_ready_q;
    div_d     = apply ? pend_q : cur_div_q;
    cnt_d     = wrap ? '0 : cnt_q + DIV_W'(1);
    // The high phase is evaluated against the ratio of the period the new
    // count belongs to, so a period started by an apply uses the new N.
    clk_out_d = (cnt_d < (div_d >> 1));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cur_div_q   <= DIV_W'(DEFAULT_DIV);
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      cfg_ready_q <= 1'b1;
      err_q       <= 1'b0;
      clk_out_q   <= 1'b0;
      tick_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;

      // Configuration handshake. apply and xfer are mutually exclusive:
      // apply needs a pending ratio, which holds cfg_ready low.
      if (apply) begin
        cur_div_q   <= pend_q;
        pend_vld_q  <= 1'b0;
        cfg_ready_q <= 1'b1;
      end else if (xfer) begin
        if (cfg_div < DIV_W'(2)) begin
          err_q <= 1'b1;
        end else begin
          pend_q      <= cfg_div;
          pend_vld_q  <= 1'b1;
          cfg_ready_q <= 1'b0;
        end
      end

      case (state_q)
        S_IDLE: begin
          cnt_q     <= '0;
          clk_out_q <= 1'b0;
          tick_q    <= 1'b0;
          busy_q    <= 1'b0;
          // stop has priority over start.
          if (start && !stop) begin
            state_q   <= S_RUN;
            clk_out_q <= 1'b1;
            tick_q    <= 1'b1;
            busy_q    <= 1'b1;
          end
        end

        S_RUN: begin
          cnt_q     <= cnt_d;
          tick_q    <= wrap;
          clk_out_q <= clk_out_d;
          if (stop) begin
            if (wrap) begin
              // Stop seen on the last cycle of a period: finish right here.
              state_q   <= S_IDLE;
              cnt_q     <= '0;
              tick_q    <= 1'b0;
              clk_out_q <= 1'b0;
              busy_q    <= 1'b0;
            end else begin
              state_q <= S_STOPPING;
            end
          end
        end

        S_STOPPING: begin
          cnt_q     <= cnt_d;
          tick_q    <= wrap;
          clk_out_q <= clk_out_d;
          if (start && !stop) begin
            // Stop cancelled; counting carries on undisturbed.
            state_q <= S_RUN;
          end else if (wrap) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            tick_q    <= 1'b0;
            clk_out_q <= 1'b0;
            busy_q    <= 1'b0;
          end
        end

        default: begin
          state_q   <= S_IDLE;
          cnt_q     <= '0;
          tick_q    <= 1'b0;
          clk_out_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign cur_div   = cur_div_q;
  assign err       = err_q;
  assign clk_out   = clk_out_q;
  assign tick      = tick_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_wave_clk_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wave_clk_ctrl
//
// Directed bench for wave_clk_ctrl. Inputs change 1 ns after a rising edge and
// outputs are sampled at that same point, so each sample reflects the edge
// just taken. Expected values are hand-derived from the controller behaviour.
// -----------------------------------------------------------------------------
module tb_wave_clk_ctrl;

  localparam int DIV_W = 16;

  logic             clk_in = 1'b0;
  logic             reset;
  logic             start;
  logic             stop;
  logic             cfg_valid;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_ready;
  logic [DIV_W-1:0] cur_div;
  logic             err;
  logic             clk_out;
  logic             tick;
  logic             busy;

  int errors = 0;
  int checks = 0;

  wave_clk_ctrl #(.DIV_W(DIV_W), .DEFAULT_DIV(4)) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cur_div   (cur_div),
    .err       (err),
    .clk_out   (clk_out),
    .tick      (tick),
    .busy      (busy)
  );

  always #10 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  // {clk_out, tick, busy} expected for a running period of length n at count c.
  function automatic logic [2:0] run_exp(int n, int c);
    return {logic'(c < n / 2), logic'(c == 0), 1'b1};
  endfunction

  task automatic test_reset();
    do_reset();
    checks++;
    if ({clk_out, tick, err, cfg_ready, busy} !== 5'b00010) begin
      errors++;
      $display("FAIL reset_outputs: got clk_out,tick,err,cfg_ready,busy=%b want 00010",
               {clk_out, tick, err, cfg_ready, busy});
    end
    checks++;
    if (cur_div !== 16'd4) begin
      errors++;
      $display("FAIL reset_cur_div: got %0d want 4", cur_div);
    end
  endtask

  task automatic test_default_ratio();
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if ({clk_out, tick, busy} !== run_exp(4, i % 4)) begin
        errors++;
        $display("FAIL default_ratio cycle %0d: got clk_out,tick,busy=%b want %b",
                 i, {clk_out, tick, busy}, run_exp(4, i % 4));
      end
      step();
    end
    checks++;
    if (cur_div !== 16'd4) begin
      errors++;
      $display("FAIL default_cur_div: got %0d want 4", cur_div);
    end
  endtask

  task automatic test_update_run();
    do_reset();
    start = 1'b1;
    step();                       // cnt 0
    start = 1'b0;
    step();                       // cnt 1
    cfg_valid = 1'b1;
    cfg_div   = 16'd6;
    step();                       // captured, cnt 2
    checks++;
    if ({cfg_ready, cur_div} !== {1'b0, 16'd4}) begin
      errors++;
      $display("FAIL update_capture: got cfg_ready=%b cur_div=%0d want 0 / 4", cfg_ready, cur_div);
    end
    // Offer while not ready: must be ignored, no err, pending kept.
    cfg_div = 16'd1;
    step();                       // cnt 3
    cfg_valid = 1'b0;
    checks++;
    if ({cfg_ready, err, cur_div, clk_out} !== {1'b0, 1'b0, 16'd4, 1'b0}) begin
      errors++;
      $display("FAIL update_ignored: got cfg_ready=%b err=%b cur_div=%0d clk_out=%b want 0 0 4 0",
               cfg_ready, err, cur_div, clk_out);
    end
    step();                       // wrap edge applies 6
    checks++;
    if ({cfg_ready, cur_div} !== {1'b1, 16'd6}) begin
      errors++;
      $display("FAIL update_apply: got cfg_ready=%b cur_div=%0d want 1 / 6", cfg_ready, cur_div);
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if ({clk_out, tick, busy} !== run_exp(6, i % 6)) begin
        errors++;
        $display("FAIL update_period6 cycle %0d: got clk_out,tick,busy=%b want %b",
                 i, {clk_out, tick, busy}, run_exp(6, i % 6));
      end
      step();
    end
  endtask

  task automatic test_reject_odd();
    do_reset();
    cfg_valid = 1'b1;
    cfg_div   = 16'd1;
    step();
    cfg_valid = 1'b0;
    checks++;
    if ({err, cfg_ready, cur_div} !== {1'b1, 1'b1, 16'd4}) begin
      errors++;
      $display("FAIL reject_pulse: got err=%b cfg_ready=%b cur_div=%0d want 1 1 4", err, cfg_ready, cur_div);
    end
    step();
    checks++;
    if ({err, cfg_ready} !== 2'b01) begin
      errors++;
      $display("FAIL reject_one_cycle: got err=%b cfg_ready=%b want 0 1", err, cfg_ready);
    end
    cfg_valid = 1'b1;
    cfg_div   = 16'd5;
    step();                       // captured in IDLE
    cfg_valid = 1'b0;
    checks++;
    if ({cfg_ready, cur_div, busy} !== {1'b0, 16'd4, 1'b0}) begin
      errors++;
      $display("FAIL idle_capture: got cfg_ready=%b cur_div=%0d busy=%b want 0 4 0", cfg_ready, cur_div, busy);
    end
    // Start on the apply edge: the new ratio is used from cnt 0.
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({cfg_ready, cur_div} !== {1'b1, 16'd5}) begin
      errors++;
      $display("FAIL idle_apply: got cfg_ready=%b cur_div=%0d want 1 / 5", cfg_ready, cur_div);
    end
    for (int i = 0; i < 11; i++) begin
      checks++;
      if ({clk_out, tick, busy} !== run_exp(5, i % 5)) begin
        errors++;
        $display("FAIL odd_period5 cycle %0d: got clk_out,tick,busy=%b want %b",
                 i, {clk_out, tick, busy}, run_exp(5, i % 5));
      end
      step();
    end
  endtask

  task automatic test_graceful_stop();
    do_reset();
    start = 1'b1;
    step();                       // cnt 0
    start = 1'b0;
    step();                       // cnt 1
    stop = 1'b1;
    step();                       // cnt 2, STOPPING
    stop = 1'b0;
    checks++;
    if ({clk_out, tick, busy} !== 3'b001) begin
      errors++;
      $display("FAIL stop_cnt2: got clk_out,tick,busy=%b want 001", {clk_out, tick, busy});
    end
    step();                       // cnt 3
    checks++;
    if ({clk_out, tick, busy} !== 3'b001) begin
      errors++;
      $display("FAIL stop_cnt3: got clk_out,tick,busy=%b want 001", {clk_out, tick, busy});
    end
    step();                       // wrap -> IDLE
    checks++;
    if ({clk_out, tick, busy} !== 3'b000) begin
      errors++;
      $display("FAIL stop_idle: got clk_out,tick,busy=%b want 000", {clk_out, tick, busy});
    end
    step();
    checks++;
    if ({clk_out, tick, busy} !== 3'b000) begin
      errors++;
      $display("FAIL stop_stays_idle: got clk_out,tick,busy=%b want 000", {clk_out, tick, busy});
    end
    // Stop sampled on the last cycle of a period.
    start = 1'b1;
    step();                       // cnt 0
    start = 1'b0;
    step();                       // cnt 1
    step();                       // cnt 2
    step();                       // cnt 3
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++;
    if ({clk_out, tick, busy} !== 3'b000) begin
      errors++;
      $display("FAIL stop_at_last: got clk_out,tick,busy=%b want 000", {clk_out, tick, busy});
    end
  endtask

  task automatic test_start_stop();
    do_reset();
    start = 1'b1;
    stop  = 1'b1;
    step();
    step();
    checks++;
    if ({clk_out, tick, busy} !== 3'b000) begin
      errors++;
      $display("FAIL both_high_idle: got clk_out,tick,busy=%b want 000", {clk_out, tick, busy});
    end
    stop = 1'b0;
    step();                       // cnt 0
    start = 1'b0;
    step();                       // cnt 1
    stop = 1'b1;
    step();                       // cnt 2, STOPPING
    stop  = 1'b0;
    start = 1'b1;
    step();                       // cnt 3, back to RUN
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({clk_out, tick, busy} !== run_exp(4, (i + 3) % 4)) begin
        errors++;
        $display("FAIL cancel_stop cycle %0d: got clk_out,tick,busy=%b want %b",
                 i, {clk_out, tick, busy}, run_exp(4, (i + 3) % 4));
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    start = 1'b1;
    step();                       // cnt 0
    start = 1'b0;
    step();                       // cnt 1
    cfg_valid = 1'b1;
    cfg_div   = 16'd6;
    step();                       // pending 6
    cfg_valid = 1'b0;
    reset     = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({clk_out, tick, err, cfg_ready, busy, cur_div} !== {5'b00010, 16'd4}) begin
      errors++;
      $display("FAIL reset_mid: got clk_out,tick,err,cfg_ready,busy=%b cur_div=%0d want 00010 / 4",
               {clk_out, tick, err, cfg_ready, busy}, cur_div);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({clk_out, tick, busy, cur_div} !== {run_exp(4, i % 4), 16'd4}) begin
        errors++;
        $display("FAIL reset_mid_discard cycle %0d: got clk_out,tick,busy=%b cur_div=%0d want %b / 4",
                 i, {clk_out, tick, busy}, cur_div, run_exp(4, i % 4));
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_default_ratio();
    test_update_run();
    test_reject_odd();
    test_graceful_stop();
    test_start_stop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wave_clk_ctrl.md
Name: wave_clk_ctrl

Overview:
- Programmable clock-enable controller for the waveform generator datapath.
- Divides clk_in (50 MHz) by a runtime-configurable ratio N and produces a divided clock-level output plus a one-cycle period tick that the waveform logic uses as its sample enable.
- Sequences run/stop cleanly on period boundaries and applies ratio updates glitch-free through a valid/ready configuration handshake.

Parameters:
- DIV_W, 16, width of the divide ratio and internal period counter.
- DEFAULT_DIV, 4, ratio loaded at reset (50 MHz -> 12.5 MHz); must be >= 2.

Ports:
- clk_in  input  1  system clock, 50 MHz.
- reset  input  1  synchronous, active-high reset.
- start  input  1  level, sampled each edge; requests RUN.
- stop  input  1  level, sampled each edge; requests a stop at the end of the current period.
- cfg_valid  input  1  new ratio offered.
- cfg_div  input  DIV_W  offered ratio N.
- cfg_ready  output  1  controller can accept a ratio.
- cur_div  output  DIV_W  ratio currently in effect.
- err  output  1  one-cycle pulse when an offered ratio is rejected.
- clk_out  output  1  divided clock, registered.
- tick  output  1  one-cycle pulse at the first cycle of each output period.
- busy  output  1  high when state != IDLE.

Behaviour:
- All outputs registered. Single clock domain. Reset is synchronous on clk_in.
- Reset values (also on reset asserted mid-operation; takes effect at that edge, no period completion):
  - state = IDLE, cnt = 0, cur_div = DEFAULT_DIV, pending cleared.
  - clk_out = 0, tick = 0, err = 0, cfg_ready = 1, busy = 0.
- State machine states: IDLE, RUN, STOPPING.
- IDLE:
  - cnt = 0, clk_out = 0, tick = 0.
  - Edge with start = 1 and stop = 0: go to RUN, load cnt = 0, clk_out = 1, tick = 1. These are visible in the cycle after that edge (latency 1).
  - start and stop both high: stop wins, remain IDLE.
- RUN, each edge:
  - If cnt == cur_div - 1: cnt wraps to 0 and tick = 1 (period boundary). Otherwise cnt increments and tick = 0.
  - clk_out = 1 when the new cnt < (cur_div >> 1), else 0.
  - Resulting duty: N = 4 gives 1100; N = 5 gives 11000; N = 2 gives 10.
  - stop = 1 moves the state to STOPPING; counting continues unchanged.
- STOPPING:
  - Counts as in RUN.
  - At the wrap edge: go to IDLE with clk_out = 0, tick = 0, cnt = 0. No partial period is ever emitted.
  - If stop is sampled when cnt == cur_div - 1, IDLE is entered at that same edge.
  - start = 1 with stop = 0 in STOPPING returns to RUN and cancels the stop; the period is uninterrupted.
- Configuration handshake (transfer = cfg_valid && cfg_ready at an edge):
  - cfg_div < 2:
    - Rejected. err = 1 for exactly the next cycle.
    - cur_div and pending are unchanged; cfg_ready stays 1.
  - cfg_div >= 2:
    - Captured into the pending register; cfg_ready drops to 0 the next cycle.
    - In RUN or STOPPING: pending is applied at the next wrap edge. At that edge, cur_div takes the new value and the new period starts with cnt = 0 under the new N. The clk_out value for cnt = 0 uses the new N.
    - In IDLE: pending is applied at the next edge.
    - cfg_ready returns to 1 in the cycle after the apply edge.
    - A transfer in IDLE therefore holds cfg_ready low for exactly 1 cycle.
  - Apply coinciding with the IDLE -> RUN start edge: the new ratio is used from cnt = 0.
  - Apply coinciding with the STOPPING -> IDLE edge: cur_div is updated and the state enters IDLE.
  - While cfg_ready = 0, cfg_valid is ignored. There is no queueing and err is not raised.
- Width rules:
  - cnt is DIV_W bits, unsigned.
  - The maximum ratio is 2^DIV_W - 1; cur_div - 1 never underflows because cur_div >= 2.
- busy = (state != IDLE), registered alongside the state.

Test Plan:
- Default ratio: reset 2 cycles, then start pulse -> from the next cycle clk_out = 1,1,0,0 repeating; tick high on cycles 0,4,8,...; cur_div = 4; busy = 1.
- Update during RUN: N = 4, offer cfg_div = 6 at cnt = 1 -> cfg_ready = 0 until the wrap; the next period is 6 cycles with clk_out = 111000; cur_div changes to 6 at the wrap; cfg_ready = 1 the following cycle.
- Rejection and odd ratio:
  - Offer cfg_div = 1 -> err high for exactly 1 cycle; cur_div unchanged; cfg_ready stays 1.
  - Then offer cfg_div = 5 in IDLE -> cur_div = 5 after 1 cycle; start -> clk_out = 11000 repeating; tick every 5 cycles.
- Graceful stop: N = 4, stop asserted at cnt = 1 -> cnt 2,3 complete; at the wrap edge the state goes IDLE, clk_out = 0, no tick, busy = 0. Then stop at cnt = 3 -> IDLE at the next edge.
- Start/stop interaction:
  - In IDLE, start = stop = 1 -> stays IDLE.
  - In STOPPING, start = 1 -> the state returns to RUN and the tick cadence is uninterrupted.
- Reset mid-operation: assert reset during RUN with a pending ratio -> at the next edge all outputs are at reset values, cur_div = 4, the pending ratio is discarded and cfg_ready = 1.
